modexp_sequencer: RTL and testbench
===================================

Name: modexp_sequencer

Overview:
Control block for the cipher decode path: computes plaintext = cipherText^privateKey mod modulus with left-to-right square-and-multiply. It does no arithmetic itself. Every multiply-reduce is issued to a shared external multiply/modulo datapath through a start/done handshake. It replaces the free-running count/enDiv sequencing with an explicit request/response controller.

Parameters:
DATA_W, 4, width of cipherText, modulus, operands and result
KEY_W, 4, width of privateKey; number of exponent bits scanned

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
ready  output  1  high in IDLE
cipherText  input  DATA_W  base, captured on accepted start
privateKey  input  KEY_W  exponent, captured on accepted start
modulus  input  DATA_W  modulus n, captured on accepted start
dp_start  output  1  one-cycle pulse issuing a datapath operation
dp_a  output  DATA_W  operand A, held stable until dp_done
dp_b  output  DATA_W  operand B, held stable until dp_done
dp_mod  output  DATA_W  modulus to datapath
dp_done  input  1  datapath result valid, one-cycle pulse
dp_result  input  DATA_W  (dp_a*dp_b) mod dp_mod
done  output  1  one-cycle pulse, result valid
err  output  1  with done: modulus==0, or timeout (see Optional Feature)
plainText  output  DATA_W  result, held until next accepted start

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1. dp_start, done and err are 0. dp_a, dp_b, dp_mod and plainText are 0. Internal acc, base, exp and bit index are 0.
- Reset mid-operation aborts immediately. No done is produced. A later dp_done is ignored in IDLE.
- IDLE -> CHECK on start && ready. Inputs are registered in that cycle. start while busy is ignored; no queueing.
- CHECK:
  - n==0: go to FINISH with err=1, plainText=0.
  - n==1: go to FINISH with plainText=0 and no datapath ops.
  - Otherwise go to REDUCE.
- REDUCE: issue base*1 mod n. On dp_done: base<=dp_result, acc<=1, idx<=KEY_W-1, go to SQUARE.
- SQUARE: issue acc*acc. On dp_done: acc<=result. If exp[idx]=1 go to MULT, else go to NEXT.
- MULT: issue acc*base. On dp_done: acc<=result, go to NEXT.
- NEXT (1 cycle): if idx==0 go to FINISH, else idx<=idx-1 and go to SQUARE.
- FINISH: done=1 for one cycle, plainText<=acc (or 0 per CHECK), go to IDLE. ready rises the cycle after done.
- Issue protocol:
  - dp_start pulses for exactly one cycle on entry to an issuing state. dp_a, dp_b and dp_mod are driven in that same cycle.
  - Operands are held until the state is left. dp_done is only sampled in issuing states.
  - dp_done in the same cycle as dp_start is legal (zero-latency datapath) and counts as the response.
- Operation count: all KEY_W bits are scanned, leading zeros included. Ops = 1 + KEY_W + popcount(exp). Exponent 0 yields acc=1 (n>1).
- Widths: all operands are DATA_W. Results are assumed < n, so no truncation.

Optional Feature:
MODEXP_TIMEOUT_EN
- With the macro: an 8-bit watchdog counts cycles while waiting for dp_done. At 255 it forces FINISH with err=1 and plainText=0.
- Without the macro: the controller waits indefinitely and err only flags modulus==0.

Decomposition:
Package modexp_pkg holds:
- state enum (IDLE, CHECK, REDUCE, SQUARE, MULT, NEXT, FINISH)
- DATA_W/KEY_W defaults
- timeout limit constant

Sub-module: modexp_dp_issue, a single-op request register that drives dp_start, latches operands and handles the dp_done capture.

Test Plan:
- c=4, d=3, n=7, datapath latency 2 -> plainText=1; 1+4+2=7 dp_start pulses; err=0.
- c=9, d=5, n=13 -> plainText=3; 7 dp_start pulses.
- c=5, d=0, n=7 -> plainText=1; 5 ops. Then c=5, d=15, n=1 -> plainText=0; zero dp_start pulses.
- n=0 -> done with err=1, plainText=0, no dp_start. A start pulsed while busy during another op is ignored; its inputs are not captured.
- Assert RST_N low mid-SQUARE -> all outputs 0 and ready=1 asynchronously. A stray dp_done afterwards causes no done. A fresh c=4, d=3, n=7 then yields 1.
- With MODEXP_TIMEOUT_EN, never return dp_done -> done and err assert 256 cycles after dp_start; plainText=0.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared constants and state encoding for the modular-exponentiation sequencer.
// The datapath watchdog (MODEXP_TIMEOUT_EN) uses TIMEOUT_LIMIT.
package modexp_pkg;

    localparam int DATA_W_DEF    = 4;
    localparam int KEY_W_DEF     = 4;
    localparam int TIMEOUT_LIMIT = 255;

    typedef logic [2:0] stateT;

    localparam stateT ST_IDLE   = 3'd0;
    localparam stateT ST_CHECK  = 3'd1;
    localparam stateT ST_REDUCE = 3'd2;
    localparam stateT ST_SQUARE = 3'd3;
    localparam stateT ST_MULT   = 3'd4;
    localparam stateT ST_NEXT   = 3'd5;
    localparam stateT ST_FINISH = 3'd6;

endpackage

// File: rtl/modexp_dp_issue.sv
// Single-outstanding request register toward the shared multiply/modulo datapath.
// Optional MODEXP_TIMEOUT_EN adds a down-counting watchdog on the pending request.
module modexp_dp_issue
    import modexp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              issue,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    input  logic [DATA_W-1:0] opMod,
    input  logic              dp_done,
    output logic              dp_start,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    output logic [DATA_W-1:0] dp_mod,
    output logic              opDone,
    output logic              timeout
);

    logic waiting;

    // waiting is set on the same edge dp_start rises, so a zero-latency dp_done counts
    assign opDone = waiting & dp_done;

`ifdef MODEXP_TIMEOUT_EN
    logic [7:0] wdog;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wdog <= 8'd0;
        end else if (issue) begin
            wdog <= 8'(TIMEOUT_LIMIT);
        end else if (waiting && (wdog != 8'd0)) begin
            wdog <= wdog - 8'd1;
        end
    end

    assign timeout = waiting & ~dp_done & (wdog == 8'd0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dp_start <= 1'b0;
            dp_a     <= '0;
            dp_b     <= '0;
            dp_mod   <= '0;
            waiting  <= 1'b0;
        end else begin
            dp_start <= issue;
            if (issue) begin
                dp_a    <= opA;
                dp_b    <= opB;
                dp_mod  <= opMod;
                waiting <= 1'b1;
            end else if (opDone || timeout) begin
                waiting <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply controller; all multiply-reduce work goes to an
// external datapath. MODEXP_TIMEOUT_EN enables the datapath watchdog in modexp_dp_issue.
//   state  | meaning
//   IDLE   | ready, waiting for start
//   CHECK  | screen modulus 0 / 1
//   REDUCE | base*1 mod n
//   SQUARE | acc*acc mod n
//   MULT   | acc*base mod n
//   NEXT   | advance exponent bit index
//   FINISH | done pulse, result valid
module modexp_sequencer
    import modexp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEY_W  = KEY_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    output logic              ready,
    input  logic [DATA_W-1:0] cipherText,
    input  logic [KEY_W-1:0]  privateKey,
    input  logic [DATA_W-1:0] modulus,
    output logic              dp_start,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    output logic [DATA_W-1:0] dp_mod,
    input  logic              dp_done,
    input  logic [DATA_W-1:0] dp_result,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] plainText
);

    localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(KEY_W - 1);

    stateT             state, nextState;
    logic [DATA_W-1:0] base, acc, nReg;
    logic [KEY_W-1:0]  keyReg;
    logic [IDX_W-1:0]  idx;
    logic              errFlag;
    logic              issue, opDone, timeout;
    logic [DATA_W-1:0] issueA, issueB;
    logic              zeroRes, errNext;

    modexp_dp_issue #(.DATA_W(DATA_W)) uIssue (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .issue    (issue),
        .opA      (issueA),
        .opB      (issueB),
        .opMod    (nReg),
        .dp_done  (dp_done),
        .dp_start (dp_start),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .dp_mod   (dp_mod),
        .opDone   (opDone),
        .timeout  (timeout)
    );

    // Operands for the next issue come from the values the registers take on this edge
    always_comb begin
        nextState = state;
        issue     = 1'b0;
        issueA    = acc;
        issueB    = acc;
        zeroRes   = 1'b0;
        errNext   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) nextState = ST_CHECK;
            end
            ST_CHECK: begin
                if (nReg == '0) begin
                    nextState = ST_FINISH;
                    zeroRes   = 1'b1;
                    errNext   = 1'b1;
                end else if (nReg == DATA_W'(1)) begin
                    nextState = ST_FINISH;
                    zeroRes   = 1'b1;
                end else begin
                    nextState = ST_REDUCE;
                    issue     = 1'b1;
                    issueA    = base;
                    issueB    = DATA_W'(1);
                end
            end
            ST_REDUCE: begin
                if (opDone) begin
                    nextState = ST_SQUARE;
                    issue     = 1'b1;
                    issueA    = DATA_W'(1);
                    issueB    = DATA_W'(1);
                end
            end
            ST_SQUARE: begin
                if (opDone) begin
                    if (keyReg[idx]) begin
                        nextState = ST_MULT;
                        issue     = 1'b1;
                        issueA    = dp_result;
                        issueB    = base;
                    end else begin
                        nextState = ST_NEXT;
                    end
                end
            end
            ST_MULT: begin
                if (opDone) nextState = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx == '0) begin
                    nextState = ST_FINISH;
                end else begin
                    nextState = ST_SQUARE;
                    issue     = 1'b1;
                end
            end
            ST_FINISH: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
        if (timeout) begin
            nextState = ST_FINISH;
            issue     = 1'b0;
            zeroRes   = 1'b1;
            errNext   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            base      <= '0;
            acc       <= '0;
            nReg      <= '0;
            keyReg    <= '0;
            idx       <= '0;
            plainText <= '0;
            errFlag   <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base   <= cipherText;
                        keyReg <= privateKey;
                        nReg   <= modulus;
                    end
                end
                ST_REDUCE: begin
                    if (opDone) begin
                        base <= dp_result;
                        acc  <= DATA_W'(1);
                        idx  <= IDX_TOP;
                    end
                end
                ST_SQUARE, ST_MULT: begin
                    if (opDone) acc <= dp_result;
                end
                ST_NEXT: begin
                    if (idx != '0) idx <= idx - 1'b1;
                end
                default: ;
            endcase
            if ((nextState == ST_FINISH) && (state != ST_FINISH)) begin
                plainText <= zeroRes ? '0 : acc;
                errFlag   <= errNext;
            end
        end
    end

    assign ready = (state == ST_IDLE);
    assign done  = (state == ST_FINISH);
    assign err   = done & errFlag;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Scoreboard bench for modexp_sequencer: a behavioural datapath answers each request,
// and a monitor checks every done against a repeated-multiplication reference.
module tb_modexp_sequencer;

    localparam int DW = 4;
    localparam int KW = 4;

    logic          CLK, RST_N, start, ready;
    logic [DW-1:0] cipherText, modulus, dp_a, dp_b, dp_mod, dp_result, plainText;
    logic [KW-1:0] privateKey;
    logic          dp_start, dp_done, done, err;

    typedef struct {
        int plain;
        int errv;
        int ops;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  doneCount = 0;
    int  dpOps = 0;
    int  fixedLat = -1;
    bit  dpHang = 1'b0;
    int  cycle = 0;
    int  lastStartCycle = 0;
    int  lastDoneCycle = 0;

    modexp_sequencer #(.DATA_W(DW), .KEY_W(KW)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .ready      (ready),
        .cipherText (cipherText),
        .privateKey (privateKey),
        .modulus    (modulus),
        .dp_start   (dp_start),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_mod     (dp_mod),
        .dp_done    (dp_done),
        .dp_result  (dp_result),
        .done       (done),
        .err        (err),
        .plainText  (plainText)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: c^d mod n by plain repeated multiplication
    function automatic int refPlain(input int c, input int d, input int n);
        int r;
        if (n < 2) return 0;
        r = 1;
        for (int i = 0; i < d; i++) r = (r * c) % n;
        return r;
    endfunction

    function automatic int refOps(input int d, input int n);
        int ones;
        if (n < 2) return 0;
        ones = 0;
        for (int i = 0; i < KW; i++) ones += (d >> i) & 1;
        return 1 + KW + ones;
    endfunction

    // Behavioural multiply/modulo datapath
    initial begin
        dp_done   = 1'b0;
        dp_result = '0;
        forever begin
            @(negedge CLK);
            dp_done = 1'b0;
            if (RST_N && dp_start) begin
                int lat, a, b, m;
                dpOps++;
                lastStartCycle = cycle;
                a = int'(dp_a);
                b = int'(dp_b);
                m = int'(dp_mod);
                if (!dpHang) begin
                    lat = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
                    repeat (lat) @(negedge CLK);
                    dp_result = (m == 0) ? '0 : DW'((a * b) % m);
                    dp_done   = 1'b1;
                end
            end
        end
    end

    // Monitor
    initial begin
        bit  prevDone;
        expT e;
        prevDone = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prevDone = 1'b0;
            end else begin
                if (prevDone) chk("done_pulse_then_ready", int'({done, ready}), 1);
                if (done) begin
                    doneCount++;
                    lastDoneCycle = cycle;
                    if (expQ.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        chk("plainText", int'(plainText), e.plain);
                        chk("err", int'(err), e.errv);
                        chk("dp_ops", dpOps, e.ops);
                    end
                end
                prevDone = done;
            end
        end
    end

    task automatic startOpExp(input int c, input int d, input int n,
                              input int plain, input int errv, input int ops);
        int w;
        expT e;
        w = 0;
        while (!ready && w < 1000) begin
            @(negedge CLK);
            w++;
        end
        if (!ready) chk("ready_timeout", int'(ready), 1);
        start      = 1'b1;
        cipherText = DW'(c);
        privateKey = KW'(d);
        modulus    = DW'(n);
        e.plain = plain;
        e.errv  = errv;
        e.ops   = ops;
        expQ.push_back(e);
        dpOps = 0;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic startOp(input int c, input int d, input int n);
        startOpExp(c, d, n, refPlain(c, d, n), (n == 0) ? 1 : 0, refOps(d, n));
    endtask

    task automatic waitDone(input int target);
        int w;
        w = 0;
        while (doneCount < target && w < 5000) begin
            @(negedge CLK);
            w++;
        end
        chk("done_reached", doneCount, target);
        @(negedge CLK);
    endtask

    initial begin
        int base, w;
        RST_N      = 1'b0;
        start      = 1'b0;
        cipherText = '0;
        privateKey = '0;
        modulus    = '0;

        #12;
        chk("reset_outputs", int'({ready, dp_start, done, err, dp_a, dp_b, dp_mod, plainText}),
            int'(20'h80000));
        #11 RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_outputs", int'({ready, dp_start, done, err, plainText}), int'(8'h80));

        fixedLat = 2;
        startOp(4, 3, 7);
        waitDone(1);

        // start while busy must be ignored
        fixedLat = 1;
        startOp(9, 5, 13);
        repeat (3) @(negedge CLK);
        start      = 1'b1;
        cipherText = 4'd2;
        privateKey = 4'd7;
        modulus    = 4'd11;
        @(negedge CLK);
        start = 1'b0;
        waitDone(2);
        repeat (5) @(negedge CLK);
        chk("busy_start_ignored", doneCount, 2);

        fixedLat = 0;
        startOp(5, 0, 7);
        waitDone(3);
        startOp(5, 15, 1);
        waitDone(4);
        startOp(3, 6, 0);
        waitDone(5);

        // async reset during the first SQUARE
        fixedLat = 8;
        startOp(4, 3, 7);
        w = 0;
        while (dpOps < 2 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        chk("reached_square", dpOps, 2);
        #2 RST_N = 1'b0;
        #1;
        chk("reset_async", int'({ready, dp_start, done, err, dp_a, dp_b, dp_mod, plainText}),
            int'(20'h80000));
        expQ.delete();
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b1;
        base = doneCount;
        repeat (15) @(negedge CLK);
        chk("no_done_after_reset", doneCount, base);
        fixedLat = -1;
        startOp(4, 3, 7);
        waitDone(base + 1);

        for (int i = 0; i < 40; i++) begin
            int c, d, n;
            c = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 15));
            n = int'($urandom_range(0, 15));
            startOp(c, d, n);
            waitDone(base + 2 + i);
        end

`ifdef MODEXP_TIMEOUT_EN
        dpHang = 1'b1;
        base = doneCount;
        startOpExp(4, 3, 7, 0, 1, 1);
        waitDone(base + 1);
        chk("timeout_latency", lastDoneCycle - lastStartCycle, 256);
        dpHang = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
